// File: rtl/e_pkg.sv
// ============================================================================
// Module      : e_pkg
// Description : Width helpers shared by the slot allocator and its search.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package e_pkg;

    function automatic int id_w(input int w);
        return $clog2(w);
    endfunction

    function automatic int cnt_w(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/math_pkg.sv
// ============================================================================
// Module      : math_pkg
// Description : Small elaboration-time arithmetic helpers.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package math_pkg;

    function automatic int div_ceil(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

endpackage

`default_nettype wire

// File: rtl/e_multi.sv
// ============================================================================
// Module      : e_multi
// Description : Circular zero-search: first clear bit of x at pos-1, pos-2, ...
//               (mod W), built as a radix-RADIX_N two-level priority tree.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_multi
    import math_pkg::*;
    import e_pkg::*;
#(
    parameter int W       = 32,
    parameter int RADIX_N = 4
) (
    input  logic [W-1:0]         x,
    input  logic [id_w(W)-1:0]   pos,
    output logic                 any,
    output logic [id_w(W)-1:0]   y_enc
);

    localparam int IDW = id_w(W);
    localparam int NG  = div_ceil(W, RADIX_N);
    localparam int OW  = $clog2(RADIX_N);
    localparam int PW  = NG * RADIX_N;

    // z[j] is set when slot (pos-1-j) mod W is free, so the lowest set bit wins
    logic [PW-1:0] z;
    logic [NG-1:0] grp_any;
    logic [OW-1:0] grp_off [NG];
    logic [IDW:0]  idx;
    logic [IDW:0]  sel_j;
    logic [IDW:0]  wrap;

    always_comb begin
        z   = '0;
        idx = '0;
        for (int j = 0; j < W; j++) begin
            idx = {1'b0, pos} + (IDW+1)'(W - 1 - j);
            if (idx >= (IDW+1)'(W))
                idx = idx - (IDW+1)'(W);
            z[j] = ~x[idx[IDW-1:0]];
        end
    end

    always_comb begin
        for (int g = 0; g < NG; g++) begin
            grp_any[g] = |z[g*RADIX_N +: RADIX_N];
            grp_off[g] = '0;
            for (int k = RADIX_N - 1; k >= 0; k--)
                if (z[g*RADIX_N + k])
                    grp_off[g] = OW'(k);
        end
    end

    always_comb begin
        any   = |grp_any;
        sel_j = '0;
        for (int g = NG - 1; g >= 0; g--)
            if (grp_any[g])
                sel_j = (IDW+1)'(g * RADIX_N) + (IDW+1)'(grp_off[g]);
        wrap = {1'b0, pos} + (IDW+1)'(W - 1) - sel_j;
        if (wrap >= (IDW+1)'(W))
            wrap = wrap - (IDW+1)'(W);
        y_enc = wrap[IDW-1:0];
    end

endmodule

`default_nettype wire

// File: rtl/e_slot_alloc.sv
// ============================================================================
// Module      : e_slot_alloc
// Description : Round-robin slot allocator with valid/ready issue and a free
//               port. Optional macro E_SLOT_ALLOC_FREE_BYPASS_EN lets a slot
//               freed on this edge be searched on the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module e_slot_alloc
    import e_pkg::*;
#(
    parameter int W       = 32,
    parameter int RADIX_N = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  alloc_vld_o,
    input  logic                  alloc_rdy_i,
    output logic [id_w(W)-1:0]    alloc_id_o,
    input  logic                  free_vld_i,
    input  logic [id_w(W)-1:0]    free_id_i,
    output logic                  full_o,
    output logic [cnt_w(W)-1:0]   cnt_o
);

    localparam int CW = cnt_w(W);

    typedef logic [id_w(W)-1:0] slot_id_t;
    typedef logic [W-1:0]       slot_vec_t;

    slot_vec_t       busy_r;
    slot_id_t        ptr_r;
    logic            out_vld_r;
    slot_id_t        out_id_r;
    logic [CW-1:0]   cnt_r;

    slot_vec_t       busy_srch;
    slot_vec_t       free_mask;
    slot_vec_t       set_mask;
    slot_vec_t       clr_mask;
    slot_id_t        y_enc;
    logic            any;
    logic            load;
    logic            free_ok;

    always_comb begin
        free_mask = free_vld_i ? (slot_vec_t'(1) << free_id_i) : '0;
        free_ok   = |(free_mask & busy_r);
`ifdef E_SLOT_ALLOC_FREE_BYPASS_EN
        busy_srch = busy_r & ~free_mask;
`else
        busy_srch = busy_r;
`endif
        load      = any & (~out_vld_r | alloc_rdy_i);
        set_mask  = load ? (slot_vec_t'(1) << y_enc) : '0;
        clr_mask  = free_ok ? free_mask : '0;
    end

    e_multi #(
        .W       (W),
        .RADIX_N (RADIX_N)
    ) u_e_multi (
        .x     (busy_srch),
        .pos   (ptr_r),
        .any   (any),
        .y_enc (y_enc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            busy_r    <= '0;
            ptr_r     <= '0;
            out_vld_r <= 1'b0;
            out_id_r  <= '0;
            cnt_r     <= '0;
        end else begin
            // set after clear so a same-bit collision leaves the slot busy
            busy_r <= (busy_r & ~clr_mask) | set_mask;
            if (load) begin
                out_id_r  <= y_enc;
                out_vld_r <= 1'b1;
                ptr_r     <= y_enc;
            end else if (out_vld_r && alloc_rdy_i) begin
                out_vld_r <= 1'b0;
            end
            case ({load, free_ok})
                2'b10:   cnt_r <= cnt_r + CW'(1);
                2'b01:   cnt_r <= cnt_r - CW'(1);
                default: cnt_r <= cnt_r;
            endcase
        end
    end

    assign alloc_vld_o = out_vld_r;
    assign alloc_id_o  = out_id_r;
    assign cnt_o       = cnt_r;
    assign full_o      = (busy_r == '1);

`ifdef ASSERT
    a_cnt_popcount: assert property (@(posedge clk) disable iff (!rst_n)
        cnt_r == CW'($countones(busy_r)));
    a_id_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (alloc_vld_o && !alloc_rdy_i) |=> (alloc_vld_o && $stable(alloc_id_o)));
`endif

endmodule

`default_nettype wire

// File: tb/tb_e_slot_alloc.sv
// ============================================================================
// Module      : tb_e_slot_alloc
// Description : Scoreboard bench for e_slot_alloc (W=8, RADIX_N=4) with a
//               behavioural pool model, directed scenarios and random traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_e_slot_alloc;

    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       alloc_vld_o;
    logic       alloc_rdy_i = 1'b0;
    logic [2:0] alloc_id_o;
    logic       free_vld_i = 1'b0;
    logic [2:0] free_id_i = 3'd0;
    logic       full_o;
    logic [3:0] cnt_o;

    e_slot_alloc #(.W(W), .RADIX_N(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc_vld_o (alloc_vld_o),
        .alloc_rdy_i (alloc_rdy_i),
        .alloc_id_o  (alloc_id_o),
        .free_vld_i  (free_vld_i),
        .free_id_i   (free_id_i),
        .full_o      (full_o),
        .cnt_o       (cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct { bit vld; int cnt; bit full; } st_t;

    int  n_vec = 0;
    int  n_err = 0;
    bit  m_busy [W];
    int  m_ptr = 0;
    bit  m_vld = 1'b0;
    int  m_sid = 0;
    int  sidq [$];
    st_t stq [$];

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Pool model: a slot is handed out by scanning ptr-1, ptr-2, ... for the first free one
    task automatic model_step(input bit r, input bit rdy, input bit fv, input int fid);
        bit  srch [W];
        int  found;
        int  idx;
        bit  fr;
        st_t e;
        if (!r) begin
            for (int i = 0; i < W; i++) m_busy[i] = 1'b0;
            m_ptr = 0;
            m_vld = 1'b0;
            m_sid = 0;
            sidq.delete();
        end else begin
            fr   = fv && m_busy[fid];
            srch = m_busy;
`ifdef E_SLOT_ALLOC_FREE_BYPASS_EN
            if (fv) srch[fid] = 1'b0;
`endif
            found = -1;
            for (int k = 1; k <= W; k++) begin
                idx = ((m_ptr - k) % W + W) % W;
                if (!srch[idx]) begin
                    found = idx;
                    break;
                end
            end
            if (fr) m_busy[fid] = 1'b0;
            if (found >= 0 && (!m_vld || rdy)) begin
                m_busy[found] = 1'b1;
                m_ptr = found;
                m_vld = 1'b1;
                m_sid = found;
                sidq.push_back(found);
            end else if (m_vld && rdy) begin
                m_vld = 1'b0;
            end
        end
        e.vld = m_vld;
        e.cnt = 0;
        for (int i = 0; i < W; i++) e.cnt += int'(m_busy[i]);
        e.full = (e.cnt == W);
        stq.push_back(e);
    endtask

    task automatic step(input bit r, input bit rdy, input bit fv, input int fid);
        @(negedge clk);
        #1;
        rst_n       = r;
        alloc_rdy_i = rdy;
        free_vld_i  = fv;
        free_id_i   = 3'(fid);
        model_step(r, rdy, fv, fid);
    endtask

    // Directed check of the state left by the previous edge
    task automatic chk(input string name, input bit vld, input int cnt, input bit full, input int id);
        check({name, "_vld"}, int'(alloc_vld_o), int'(vld));
        check({name, "_cnt"}, int'(cnt_o), cnt);
        check({name, "_full"}, int'(full_o), int'(full));
        if (id >= 0) check({name, "_id"}, int'(alloc_id_o), id);
    endtask

    // Monitor: compare per-cycle state, then pop the scoreboard on each handshake
    always begin
        st_t e;
        @(negedge clk);
        if (stq.size() > 0) begin
            e = stq.pop_front();
            check("mon_vld", int'(alloc_vld_o), int'(e.vld));
            check("mon_cnt", int'(cnt_o), e.cnt);
            check("mon_full", int'(full_o), int'(e.full));
            if (e.vld && sidq.size() > 0)
                check("mon_offer_id", int'(alloc_id_o), sidq[0]);
        end
        #2;
        if (rst_n && alloc_vld_o && alloc_rdy_i) begin
            if (sidq.size() == 0)
                check("hs_unexpected", 1, 0);
            else
                check("hs_id", int'(alloc_id_o), sidq.pop_front());
        end
    end

    initial begin
        bit rdy;
        bit fv;
        int fid;
        bit r;

        // reset then stream the whole pool
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("exhaust", 1'b0, 8, 1'b1, -1);

        // full pool, free ID 3 and watch it come back
        step(1, 0, 1, 3);
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("reissue3", 1'b1, 8, 1'b1, 3);
        step(1, 1, 0, 0);

        // back-pressure after reset
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
        step(1, 1, 0, 0);
        chk("hold7", 1'b1, 1, 1'b0, 7);
        step(1, 1, 0, 0);
        chk("next6", 1'b1, 2, 1'b0, 6);

        // free of 5 coinciding with an accept
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        step(1, 1, 1, 5);
        step(1, 0, 0, 0);
        chk("free_acc", 1'b1, 4, 1'b0, 3);

        // free of a non-busy slot right after reset
        step(0, 0, 0, 0);
        step(1, 1, 1, 2);
        for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
        step(1, 0, 0, 0);
        chk("nofree", 1'b0, 8, 1'b1, -1);

        // reset mid-stream
        step(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
        step(0, 1, 1, 6);
        step(1, 0, 0, 0);
        chk("midrst", 1'b0, 0, 1'b0, -1);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0);

        // random traffic
        for (int i = 0; i < 800; i++) begin
            r   = ($urandom_range(0, 99) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            fv  = ($urandom_range(0, 9) < 4);
            fid = $urandom_range(0, W - 1);
            if (m_vld && fid == m_sid) fv = 1'b0;
            step(r, rdy, fv, fid);
        end

        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        @(negedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
